// File: rtl/dsp48a1_slice_pkg.sv
// Shared definitions for the DSP48A1-style slice: OPMODE bit positions,
// X/Z multiplexer encodings and the string values accepted by the
// CARRYINSEL and B_INPUT parameters.
package dsp48a1_slice_pkg;

  // OPMODE field positions
  localparam int OM_X_LSB    = 0;
  localparam int OM_Z_LSB    = 2;
  localparam int OM_PRE_SEL  = 4;  // 1: B1 takes pre-adder result, 0: B0
  localparam int OM_CARRY    = 5;  // carry-in when CARRYINSEL selects OPMODE5
  localparam int OM_PRE_SUB  = 6;  // 1: pre-adder computes D-B
  localparam int OM_POST_SUB = 7;  // 1: post-adder computes Z-(X+CIN)

  // X multiplexer selections (OPMODE[1:0])
  typedef enum logic [1:0] {
    X_ZERO = 2'd0,
    X_M    = 2'd1,
    X_P    = 2'd2,
    X_DAB  = 2'd3
  } x_sel_e;

  // Z multiplexer selections (OPMODE[3:2])
  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_P    = 2'd2,
    Z_C    = 2'd3
  } z_sel_e;

  // Accepted string values for source-select parameters
  localparam string CYI_OPMODE5 = "OPMODE5";
  localparam string CYI_CARRYIN = "CARRYIN";
  localparam string B_DIRECT    = "DIRECT";
  localparam string B_CASCADE   = "CASCADE";

endpackage

// File: rtl/dsp48a1_slice_reg_mux.sv
// Optional pipeline stage: a register with asynchronous clear and clock
// enable when RSEL is 1, or a plain wire when RSEL is 0. The register is
// always described so the control inputs stay connected; in bypass mode
// its output is simply not selected and it is trimmed away.
module dsp_reg_mux #(
  parameter int WIDTH = 18,
  parameter int RSEL  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r;

  // Stage register: reset overrides enable, enable gates the load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '0;
    end else if (ce) begin
      r <= d;
    end
  end

  assign q = (RSEL != 0) ? r : d;

endmodule

// File: rtl/dsp48a1_slice.sv
// DSP48A1-style arithmetic slice: 18-bit pre-adder (D +/- B), unsigned
// 18x18 multiplier and 48-bit post-adder/accumulator with optional
// pipeline registers and B/P cascade ports.
module dsp48a1_slice
  import dsp48a1_slice_pkg::*;
#(
  parameter int    A0REG       = 0,
  parameter int    A1REG       = 1,
  parameter int    B0REG       = 0,
  parameter int    B1REG       = 1,
  parameter int    CREG        = 1,
  parameter int    DREG        = 1,
  parameter int    MREG        = 1,
  parameter int    PREG        = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter int    OPMODEREG   = 1,
  parameter string CARRYINSEL  = "OPMODE5",
  parameter string B_INPUT     = "DIRECT"
) (
  input  logic        clk,
  input  logic        RSTA,
  input  logic        RSTB,
  input  logic        RSTC,
  input  logic        RSTD,
  input  logic        RSTM,
  input  logic        RSTP,
  input  logic        RSTCARRYIN,
  input  logic        RSTOPMODE,
  input  logic        CEA,
  input  logic        CEB,
  input  logic        CEC,
  input  logic        CED,
  input  logic        CEM,
  input  logic        CEP,
  input  logic        CECARRYIN,
  input  logic        CEOPMODE,
  input  logic [17:0] A,
  input  logic [17:0] B,
  input  logic [17:0] D,
  input  logic [17:0] BCIN,
  input  logic [47:0] C,
  input  logic [47:0] PCIN,
  input  logic [7:0]  OPMODE,
  input  logic        CARRYIN,
  output logic [17:0] BCOUT,
  output logic [35:0] M,
  output logic [47:0] P,
  output logic [47:0] PCOUT,
  output logic        CARRYOUT,
  output logic        CARRYOUTF
);

  localparam bit B_FROM_PORT    = (B_INPUT == B_DIRECT);
  localparam bit B_FROM_CASCADE = (B_INPUT == B_CASCADE);
  localparam bit CYI_FROM_OM    = (CARRYINSEL == CYI_OPMODE5);
  localparam bit CYI_FROM_PORT  = (CARRYINSEL == CYI_CARRYIN);

  logic [7:0]  om;
  logic [17:0] b_src, b0, a0, d0, pre_sum, b1_in, b1, a1;
  logic [47:0] c0, x_mux, z_mux, p_q;
  logic [35:0] mult, m_q;
  logic [48:0] post_sum;
  logic        cyi_src, cin, cyo_q;

  // ---- operand stage 0: OPMODE, A0, B0, C, D ----
  assign b_src = B_FROM_PORT    ? B    :
                 B_FROM_CASCADE ? BCIN : '0;

  dsp_reg_mux #(.WIDTH(8),  .RSEL(OPMODEREG)) u_om (
    .clk(clk), .rst(RSTOPMODE), .ce(CEOPMODE), .d(OPMODE), .q(om));
  dsp_reg_mux #(.WIDTH(18), .RSEL(B0REG)) u_b0 (
    .clk(clk), .rst(RSTB), .ce(CEB), .d(b_src), .q(b0));
  dsp_reg_mux #(.WIDTH(18), .RSEL(A0REG)) u_a0 (
    .clk(clk), .rst(RSTA), .ce(CEA), .d(A), .q(a0));
  dsp_reg_mux #(.WIDTH(18), .RSEL(DREG)) u_d (
    .clk(clk), .rst(RSTD), .ce(CED), .d(D), .q(d0));
  dsp_reg_mux #(.WIDTH(48), .RSEL(CREG)) u_c (
    .clk(clk), .rst(RSTC), .ce(CEC), .d(C), .q(c0));

  // ---- pre-adder and stage 1: A1, B1 ----
  assign pre_sum = om[OM_PRE_SUB] ? (d0 - b0) : (d0 + b0);
  assign b1_in   = om[OM_PRE_SEL] ? pre_sum : b0;

  dsp_reg_mux #(.WIDTH(18), .RSEL(B1REG)) u_b1 (
    .clk(clk), .rst(RSTB), .ce(CEB), .d(b1_in), .q(b1));
  dsp_reg_mux #(.WIDTH(18), .RSEL(A1REG)) u_a1 (
    .clk(clk), .rst(RSTA), .ce(CEA), .d(a0), .q(a1));

  assign BCOUT = b1;

  // ---- multiplier stage: M ----
  assign mult = {18'b0, a1} * {18'b0, b1};

  dsp_reg_mux #(.WIDTH(36), .RSEL(MREG)) u_m (
    .clk(clk), .rst(RSTM), .ce(CEM), .d(mult), .q(m_q));

  assign M = m_q;

  // ---- carry-in stage ----
  assign cyi_src = CYI_FROM_OM   ? om[OM_CARRY] :
                   CYI_FROM_PORT ? CARRYIN      : 1'b0;

  dsp_reg_mux #(.WIDTH(1), .RSEL(CARRYINREG)) u_cyi (
    .clk(clk), .rst(RSTCARRYIN), .ce(CECARRYIN), .d(cyi_src), .q(cin));

  // X operand select: zero, multiplier product, feedback P, or D:A:B concatenation
  always_comb begin
    x_mux = '0;
    case (x_sel_e'(om[OM_X_LSB +: 2]))
      X_ZERO: x_mux = '0;
      X_M:    x_mux = {12'b0, m_q};
      X_P:    x_mux = p_q;
      X_DAB:  x_mux = {d0[11:0], a1, b1};
      default: x_mux = '0;
    endcase
  end

  // Z operand select: zero, cascaded P, feedback P (accumulate) or C
  always_comb begin
    z_mux = '0;
    case (z_sel_e'(om[OM_Z_LSB +: 2]))
      Z_ZERO: z_mux = '0;
      Z_PCIN: z_mux = PCIN;
      Z_P:    z_mux = p_q;
      Z_C:    z_mux = c0;
      default: z_mux = '0;
    endcase
  end

  // 49-bit post-adder; bit 48 is the carry/borrow out
  always_comb begin
    post_sum = '0;
    if (om[OM_POST_SUB]) begin
      post_sum = {1'b0, z_mux} - ({1'b0, x_mux} + {48'b0, cin});
    end else begin
      post_sum = {1'b0, z_mux} + {1'b0, x_mux} + {48'b0, cin};
    end
  end

  // ---- output stage: P, CARRYOUT ----
  dsp_reg_mux #(.WIDTH(48), .RSEL(PREG)) u_p (
    .clk(clk), .rst(RSTP), .ce(CEP), .d(post_sum[47:0]), .q(p_q));
  dsp_reg_mux #(.WIDTH(1), .RSEL(CARRYOUTREG)) u_cyo (
    .clk(clk), .rst(RSTCARRYIN), .ce(CECARRYIN), .d(post_sum[48]), .q(cyo_q));

  assign P         = p_q;
  assign PCOUT     = p_q;
  assign CARRYOUT  = cyo_q;
  assign CARRYOUTF = cyo_q;

endmodule

// File: tb/tb_dsp48a1_slice.sv
// Bench for dsp48a1_slice: directed cases for the documented operations,
// then randomized traffic compared cycle by cycle with a reference model.
module tb_dsp48a1_slice;

  logic        clk = 1'b0;
  logic        RSTA = 0, RSTB = 0, RSTC = 0, RSTD = 0, RSTM = 0, RSTP = 0;
  logic        RSTCARRYIN = 0, RSTOPMODE = 0;
  logic        CEA = 1, CEB = 1, CEC = 1, CED = 1, CEM = 1, CEP = 1;
  logic        CECARRYIN = 1, CEOPMODE = 1;
  logic [17:0] A = 0, B = 0, D = 0, BCIN = 0;
  logic [47:0] C = 0, PCIN = 0;
  logic [7:0]  OPMODE = 0;
  logic        CARRYIN = 0;
  logic [17:0] BCOUT, cas_bcout;
  logic [35:0] M, cas_m;
  logic [47:0] P, PCOUT, cas_p, cas_pcout;
  logic        CARRYOUT, CARRYOUTF, cas_co, cas_cof;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dsp48a1_slice dut (
    .clk(clk), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD), .RSTM(RSTM),
    .RSTP(RSTP), .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE),
    .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CEM(CEM), .CEP(CEP),
    .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
    .A(A), .B(B), .D(D), .BCIN(BCIN), .C(C), .PCIN(PCIN), .OPMODE(OPMODE),
    .CARRYIN(CARRYIN), .BCOUT(BCOUT), .M(M), .P(P), .PCOUT(PCOUT),
    .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF));

  dsp48a1_slice #(.B_INPUT("CASCADE")) dut_cas (
    .clk(clk), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD), .RSTM(RSTM),
    .RSTP(RSTP), .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE),
    .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CEM(CEM), .CEP(CEP),
    .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
    .A(A), .B(B), .D(D), .BCIN(BCIN), .C(C), .PCIN(PCIN), .OPMODE(OPMODE),
    .CARRYIN(CARRYIN), .BCOUT(cas_bcout), .M(cas_m), .P(cas_p), .PCOUT(cas_pcout),
    .CARRYOUT(cas_co), .CARRYOUTF(cas_cof));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic all_rst(input logic v);
    RSTA = v; RSTB = v; RSTC = v; RSTD = v; RSTM = v; RSTP = v;
    RSTCARRYIN = v; RSTOPMODE = v;
  endtask

  task automatic set_ops(input logic [7:0] om, input logic [17:0] a, input logic [17:0] b,
                         input logic [17:0] d, input logic [47:0] c);
    OPMODE = om; A = a; B = b; D = d; C = c;
  endtask

  // Reference model state (default parameters: A0/B0 unregistered)
  logic [7:0]  r_om;
  logic [17:0] r_d, r_a1, r_b1;
  logic [47:0] r_c, r_p;
  logic [35:0] r_m;
  logic        r_cin, r_co;

  task automatic model_clear();
    r_om = 0; r_d = 0; r_a1 = 0; r_b1 = 0; r_c = 0; r_p = 0; r_m = 0;
    r_cin = 0; r_co = 0;
  endtask

  // One clock of the slice computed from the arithmetic rules
  task automatic model_step();
    longint     dv, bv, pre, xv, zv, sum;
    logic [17:0] b1n;
    logic [47:0] catv;
    logic [48:0] res;
    dv  = longint'(r_d);
    bv  = longint'(B);
    pre = r_om[6] ? (dv - bv) : (dv + bv);
    b1n = r_om[4] ? 18'(pre) : B;
    catv = {r_d[11:0], r_a1, r_b1};
    case (r_om[1:0])
      2'd0: xv = 0;
      2'd1: xv = longint'(r_m);
      2'd2: xv = longint'(r_p);
      default: xv = longint'(catv);
    endcase
    case (r_om[3:2])
      2'd0: zv = 0;
      2'd1: zv = longint'(PCIN);
      2'd2: zv = longint'(r_p);
      default: zv = longint'(r_c);
    endcase
    sum = r_om[7] ? zv - (xv + longint'(r_cin)) : zv + xv + longint'(r_cin);
    res = 49'(sum);
    if (CEP) r_p = res[47:0];
    if (CECARRYIN) begin
      r_co  = res[48];
      r_cin = r_om[5];
    end
    if (CEM) r_m = 36'(longint'(r_a1) * longint'(r_b1));
    if (CEA) r_a1 = A;
    if (CEB) r_b1 = b1n;
    if (CED) r_d = D;
    if (CEC) r_c = C;
    if (CEOPMODE) r_om = OPMODE;
  endtask

  initial begin
    // Reset with random inputs, checked before any clock edge
    set_ops(8'($urandom), 18'($urandom), 18'($urandom), 18'($urandom),
            48'({$urandom, $urandom}));
    PCIN = 48'({$urandom, $urandom});
    BCIN = 18'($urandom);
    #2;
    all_rst(1'b1);
    #1;
    check("rst_P", P, 0);
    check("rst_PCOUT", PCOUT, 0);
    check("rst_M", M, 0);
    check("rst_BCOUT", BCOUT, 0);
    check("rst_CARRYOUT", CARRYOUT, 0);
    check("rst_CARRYOUTF", CARRYOUTF, 0);

    // Plain multiply with pipeline latency
    @(negedge clk);
    all_rst(1'b0);
    set_ops(8'h01, 18'd3, 18'd4, 18'd0, 48'd0);
    clk_n(1);
    check("mul_BCOUT", BCOUT, 4);
    clk_n(1);
    check("mul_M_2clk", M, 12);
    clk_n(1);
    check("mul_P_3clk", P, 12);

    // Pre-subtract then multiply
    set_ops(8'h51, 18'd2, 18'd3, 18'd10, 48'd0);
    clk_n(5);
    check("presub_BCOUT", BCOUT, 7);
    check("presub_P", P, 14);

    // Pre-add then multiply
    set_ops(8'h11, 18'd3, 18'd2, 18'd5, 48'd0);
    clk_n(5);
    check("preadd_P", P, 21);

    // C plus carry-in wraps to zero with carry out
    set_ops(8'h2C, 18'd0, 18'd0, 18'd0, 48'hFFFF_FFFF_FFFF);
    clk_n(5);
    check("wrap_P", P, 0);
    check("wrap_CARRYOUT", CARRYOUT, 1);
    check("wrap_CARRYOUTF", CARRYOUTF, 1);

    // C minus product
    set_ops(8'h8D, 18'd2, 18'd3, 18'd0, 48'd100);
    clk_n(5);
    check("sub_P", P, 94);
    check("sub_CARRYOUT", CARRYOUT, 0);

    // Accumulate: async clear, count, freeze with CEP=0
    set_ops(8'h09, 18'd1, 18'd1, 18'd0, 48'd0);
    clk_n(5);
    RSTP = 1'b1;
    #1;
    check("acc_async_clr_P", P, 0);
    check("acc_async_clr_PCOUT", PCOUT, 0);
    check("acc_M_unaffected", M, 1);
    @(negedge clk);
    RSTP = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      clk_n(1);
      check($sformatf("acc_P_step%0d", i), P, 64'(i));
    end
    CEP = 1'b0;
    clk_n(3);
    check("acc_hold_P", P, 3);
    CEP = 1'b1;
    clk_n(1);
    check("acc_resume_P", P, 4);

    // B cascade input on the second instance
    set_ops(8'h01, 18'd2, 18'd5, 18'd0, 48'd0);
    BCIN = 18'd9;
    clk_n(5);
    check("cas_BCOUT", cas_bcout, 9);
    check("cas_M", cas_m, 18);
    check("cas_P", cas_p, 18);
    check("cas_PCOUT", cas_pcout, 18);
    check("cas_CARRYOUT", cas_co, 0);
    check("cas_CARRYOUTF", cas_cof, 0);
    check("direct_BCOUT", BCOUT, 5);

    // Randomized traffic against the reference model
    all_rst(1'b1);
    #1;
    all_rst(1'b0);
    model_clear();
    for (int cyc = 0; cyc < 400; cyc++) begin
      set_ops(8'($urandom), 18'($urandom), 18'($urandom), 18'($urandom),
              (cyc % 17 == 0) ? 48'hFFFF_FFFF_FFFF : 48'({$urandom, $urandom}));
      PCIN    = 48'({$urandom, $urandom});
      BCIN    = 18'($urandom);
      CARRYIN = 1'($urandom);
      CEA = ($urandom_range(0, 7) != 0);
      CEB = ($urandom_range(0, 7) != 0);
      CEC = ($urandom_range(0, 7) != 0);
      CED = ($urandom_range(0, 7) != 0);
      CEM = ($urandom_range(0, 7) != 0);
      CEP = ($urandom_range(0, 7) != 0);
      CECARRYIN = ($urandom_range(0, 7) != 0);
      CEOPMODE  = ($urandom_range(0, 7) != 0);
      @(posedge clk);
      model_step();
      #1;
      check("rnd_P", P, r_p);
      check("rnd_PCOUT", PCOUT, r_p);
      check("rnd_M", M, r_m);
      check("rnd_BCOUT", BCOUT, r_b1);
      check("rnd_CARRYOUT", CARRYOUT, r_co);
      check("rnd_CARRYOUTF", CARRYOUTF, r_co);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
